// File: rtl/elem_stream_ctrl.sv
// rtl/elem_stream_ctrl.sv - credit-gated stream front/back-end for int8 elementwise pipelines
//
// Accepts a ready/valid stream of int8 operand pairs and issues them to a
// non-stalling fixed-latency element pipeline. The pipeline's valid-only
// result stream is captured in a result FIFO and re-emitted as a ready/valid
// stream, with m_last marking the job's final result.
//
// Optional feature macro: ELEM_STREAM_ERR_EN
//   defined   : err is a sticky protocol error flag
//   undefined : err is tied to 0 and offending results are silently dropped
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   start, len         job start pulse and element count (sampled in IDLE)
//   busy, done         job active (RUN/DRAIN), one-cycle completion pulse
//   s_valid, s_ready   operand stream handshake
//   s_in1, s_in2       signed int8 operands
//   pe_valid           element pipeline input_valid
//   pe_in1, pe_in2     element pipeline operands (registered)
//   pe_out_valid       element pipeline result valid
//   pe_out             element pipeline result
//   m_valid, m_ready   result stream handshake
//   m_data, m_last     result and end-of-job marker
//   err                sticky protocol error flag

module elem_stream_ctrl #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic signed [7:0] s_in1,
  input  logic signed [7:0] s_in2,
  output logic              pe_valid,
  output logic signed [7:0] pe_in1,
  output logic signed [7:0] pe_in2,
  input  logic              pe_out_valid,
  input  logic [7:0]        pe_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              m_last,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]      ONE_P    = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] returned;
  logic [LEN_W-1:0] popped;
  logic [LEN_W-1:0] outstanding;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] fifo_cnt;
  logic        fifo_empty;
  logic        fifo_full;

  logic start_acc;
  logic job_go;
  logic fire;
  logic pop;
  logic push;
  logic inflight_nz;
  logic last_issue;
  logic last_pop;

  // ---------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------
  assign start_acc   = (state == IDLE) && start;
  assign job_go      = start_acc && (len != '0);
  assign outstanding = issued - popped;
  assign inflight_nz = (issued != returned);

  assign fifo_cnt    = wr_ptr - rd_ptr;
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (fifo_cnt == FULL_CNT);

  assign fire        = s_valid && s_ready;
  assign pop         = m_valid && m_ready;
  assign last_issue  = fire && (issued == len_q - ONE_L);
  assign last_pop    = pop && (popped == len_q - ONE_L);

  // A result is only accepted while a job is active and something is
  // actually in flight; a full FIFO may still take a push if it pops in
  // the same cycle. Anything else (stale results after a reset, spurious
  // valids) is dropped.
  assign push = pe_out_valid && busy && inflight_nz && (!fifo_full || pop);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (job_go)     state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_pop)   state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  // Issue credit: never let more than DEPTH elements be between issue and
  // pop, so every result the pipeline returns has a FIFO slot waiting.
  always_comb begin
    busy    = (state != IDLE);
    s_ready = (state == RUN) && (issued < len_q) && (outstanding < DEPTH_L);
  end

  // ---------------------------------------------------------------------
  // Job length and element counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q    <= '0;
      issued   <= '0;
      returned <= '0;
      popped   <= '0;
    end else if (job_go) begin
      len_q    <= len;
      issued   <= '0;
      returned <= '0;
      popped   <= '0;
    end else begin
      if (fire) issued   <= issued + ONE_L;
      if (push) returned <= returned + ONE_L;
      if (pop)  popped   <= popped + ONE_L;
    end
  end

  // ---------------------------------------------------------------------
  // Operand issue register towards the element pipeline
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_valid <= 1'b0;
      pe_in1   <= '0;
      pe_in2   <= '0;
    end else begin
      pe_valid <= fire;
      if (fire) begin
        pe_in1 <= s_in1;
        pe_in2 <= s_in2;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (job_go) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_P;
      if (pop)  rd_ptr <= rd_ptr + ONE_P;
    end
  end

  // Storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= pe_out;
    end
  end

  assign m_valid = !fifo_empty;
  assign m_data  = m_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign m_last  = m_valid && (popped == len_q - ONE_L);

  // ---------------------------------------------------------------------
  // Completion pulse: a zero-length start completes immediately, otherwise
  // the cycle after the final result leaves on the m stream.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= (start_acc && (len == '0)) || ((state == DRAIN) && last_pop);
    end
  end

  // ---------------------------------------------------------------------
  // Protocol error flag
  // ---------------------------------------------------------------------
`ifdef ELEM_STREAM_ERR_EN
  logic err_evt;

  assign err_evt = pe_out_valid && (!busy || !inflight_nz || (fifo_full && !pop));

  // Any start taken in IDLE clears the flag, even if a violation lands in
  // the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (start_acc) begin
      err <= 1'b0;
    end else if (err_evt) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_elem_stream_ctrl.sv
// tb/tb_elem_stream_ctrl.sv - self-checking bench for elem_stream_ctrl

module tb_elem_stream_ctrl;

  localparam int DEPTH = 4;
  localparam int LEN_W = 16;
  localparam int LAT   = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic signed [7:0] s_in1 = '0;
  logic signed [7:0] s_in2 = '0;
  logic              pe_valid;
  logic signed [7:0] pe_in1, pe_in2;
  logic              pe_out_valid;
  logic [7:0]        pe_out;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [7:0]        m_data;
  logic              m_last;
  logic              err;

  always #5 clk = ~clk;

  elem_stream_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_in1(s_in1), .s_in2(s_in2),
    .pe_valid(pe_valid), .pe_in1(pe_in1), .pe_in2(pe_in2),
    .pe_out_valid(pe_out_valid), .pe_out(pe_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err(err)
  );

  // Element pipeline: SUB, fixed latency, no stall, not reset by rst.
  bit [LAT-1:0]   pv;
  bit [LAT*8-1:0] pd;
  logic           inj = 1'b0;

  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], pe_valid};
    pd <= {pd[(LAT-1)*8-1:0], 8'(pe_in1 - pe_in2)};
  end

  assign pe_out_valid = pv[LAT-1] | inj;
  assign pe_out       = inj ? 8'h55 : pd[LAT*8-1 -: 8];

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Job operand table and expected results (result k = op1[k] - op2[k]).
  logic [7:0] op1 [32];
  logic [7:0] op2 [32];
  logic [7:0] exp_res [32];

  // -----------------------------------------------------------------------
  // Behavioural model and per-cycle compare. Model state describes the
  // outputs expected during the current cycle; it is advanced from the
  // inputs and handshakes seen in that cycle.
  // -----------------------------------------------------------------------
  bit         m_active = 0;
  int         m_len = 0, m_iss = 0, m_ret = 0, m_pop = 0;
  bit         m_prev_fire = 0, m_done = 0, m_err = 0;
  logic [7:0] m_prev_in1 = '0, m_prev_in2 = '0;

  always @(negedge clk) begin
    bit was_active, f, p, evt;
    if (!rst) begin
      chk1("rst_s_ready", s_ready, 1'b0);
      chk1("rst_pe_valid", pe_valid, 1'b0);
      chk8("rst_pe_in1", pe_in1, 8'h00);
      chk8("rst_pe_in2", pe_in2, 8'h00);
      chk1("rst_m_valid", m_valid, 1'b0);
      chk8("rst_m_data", m_data, 8'h00);
      chk1("rst_m_last", m_last, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      m_active = 0; m_iss = 0; m_ret = 0; m_pop = 0;
      m_prev_fire = 0; m_done = 0; m_err = 0;
    end else begin
      chk1("s_ready", s_ready, m_active && m_iss < m_len && (m_iss - m_pop) < DEPTH);
      chk1("busy", busy, m_active);
      chk1("done", done, m_done);
      chk1("pe_valid", pe_valid, m_prev_fire);
      if (m_prev_fire) begin
        chk8("pe_in1", pe_in1, m_prev_in1);
        chk8("pe_in2", pe_in2, m_prev_in2);
      end
      chk1("m_valid", m_valid, m_ret > m_pop);
      if (m_ret > m_pop) begin
        chk8("m_data", m_data, exp_res[5'(m_pop)]);
        chk1("m_last", m_last, m_pop == m_len - 1);
      end
      chk1("err", err, m_err);

      was_active = m_active;
      f = s_valid && s_ready;
      p = m_valid && m_ready;
      m_prev_fire = f;
      m_prev_in1 = s_in1;
      m_prev_in2 = s_in2;
      m_done = 0;
      evt = pe_out_valid && !(m_active && m_ret < m_iss);
      if (pe_out_valid && m_active && m_ret < m_iss) m_ret++;
      if (f) m_iss++;
      if (p && m_active) begin
        if (m_pop == m_len - 1) begin
          m_active = 0;
          m_done = 1;
        end
        m_pop++;
      end
      if (start && !was_active) begin
        if (len == '0) begin
          m_done = 1;
        end else begin
          m_active = 1; m_len = int'(len);
          m_iss = 0; m_ret = 0; m_pop = 0;
        end
      end
`ifdef ELEM_STREAM_ERR_EN
      if (start && !was_active) m_err = 0;
      else if (evt) m_err = 1;
`else
      m_err = evt ? 1'b0 : 1'b0;
`endif
    end
  end

  // -----------------------------------------------------------------------
  // Stimulus driver and observation statistics
  // -----------------------------------------------------------------------
  int         src_n = 0, src_idx = 0;
  bit         src_en = 0;
  int         fires = 0, done_cnt = 0, last_at = 0, cyc = 0;
  int         pe_cnt = 0, pe_run = 0, pe_run_max = 0, busy_seen = 0;
  int         last_m_cyc = 0, done_cyc = 0;
  logic [7:0] obs_q [$];

  task automatic clear_stats();
    fires = 0; done_cnt = 0; last_at = 0; pe_cnt = 0; pe_run = 0;
    pe_run_max = 0; busy_seen = 0; last_m_cyc = 0; done_cyc = 0;
    obs_q.delete();
  endtask

  task automatic tick();
    bit f, mf, ml;
    logic [7:0] md;
    @(negedge clk);
    f  = s_valid && s_ready;
    mf = m_valid && m_ready;
    md = m_data;
    ml = m_last;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_seen++;
    if (pe_valid) begin
      pe_cnt++; pe_run++;
      if (pe_run > pe_run_max) pe_run_max = pe_run;
    end else begin
      pe_run = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (f) begin src_idx++; fires++; end
    if (mf) begin
      obs_q.push_back(md);
      last_m_cyc = cyc;
      if (ml) last_at = obs_q.size();
    end
    s_valid = src_en && (src_idx < src_n);
    s_in1 = op1[5'(src_idx)];
    s_in2 = op2[5'(src_idx)];
  endtask

  task automatic fill_ops(input int n, input int seed);
    for (int k = 0; k < n; k++) begin
      op1[5'(k)] = 8'(k * 37 + seed);
      op2[5'(k)] = 8'(k * 11 - seed * 3);
    end
  endtask

  task automatic begin_job(input int n);
    for (int k = 0; k < n; k++) exp_res[5'(k)] = op1[5'(k)] - op2[5'(k)];
    clear_stats();
    src_n = n; src_idx = 0; src_en = 1;
    s_valid = 1'b1;
    s_in1 = op1[0];
    s_in2 = op2[0];
    len = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_cnt == 0 && c < budget) begin
      tick();
      c++;
    end
    chk1("done_timeout", done_cnt != 0, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      op1[5'(k)] = '0; op2[5'(k)] = '0; exp_res[5'(k)] = '0;
    end
    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_m_valid", m_valid, 1'b0);
    rst = 1'b1;
    repeat (2) tick();

    // Test 1: len=4, full rate, literal results of in1 - in2
    op1[0] = 8'd10;  op2[0] = 8'd3;
    op1[1] = 8'hFB;  op2[1] = 8'd7;
    op1[2] = 8'd100; op2[2] = 8'h9C;
    op1[3] = 8'd0;   op2[3] = 8'd1;
    m_ready = 1'b1;
    begin_job(4);
    wait_done(60);
    chki("t1_issues", fires, 4);
    chki("t1_pe_run", pe_run_max, 4);
    chki("t1_results", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk8("t1_r0", obs_q[0], 8'h07);
      chk8("t1_r1", obs_q[1], 8'hF4);
      chk8("t1_r2", obs_q[2], 8'hC8);
      chk8("t1_r3", obs_q[3], 8'hFF);
    end
    chki("t1_last_at", last_at, 4);
    chki("t1_done_lat", done_cyc - last_m_cyc, 0);
    chk1("t1_busy_after", busy, 1'b0);

    // Test 2: credits bound issue to DEPTH while m_ready is low
    fill_ops(10, 5);
    m_ready = 1'b0;
    begin_job(10);
    repeat (30) tick();
    chki("t2_issues_blocked", fires, 4);
    chk1("t2_s_ready_low", s_ready, 1'b0);
    m_ready = 1'b1;
    wait_done(200);
    chki("t2_issues", fires, 10);
    chki("t2_results", obs_q.size(), 10);
    chki("t2_last_at", last_at, 10);

    // Test 3: zero-length job
    src_en = 1'b0;
    s_valid = 1'b0;
    clear_stats();
    len = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chki("t3_done", done_cnt, 1);
    chki("t3_busy", busy_seen, 0);
    chki("t3_pe_valid", pe_cnt, 0);

    // Test 4: restart request during a job is ignored
    fill_ops(8, 9);
    begin_job(8);
    repeat (3) tick();
    len = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200);
    chki("t4_results", obs_q.size(), 8);
    chki("t4_last_at", last_at, 8);

    // Test 5: reset mid-job, stale pipeline results must not surface
    fill_ops(5, 2);
    begin_job(5);
    begin
      int c = 0;
      while (fires < 3 && c < 40) begin tick(); c++; end
    end
    chki("t5_pre_issues", fires, 3);
    rst = 1'b0;
    tick();
    chk1("t5_rst_pe_valid", pe_valid, 1'b0);
    chk1("t5_rst_busy", busy, 1'b0);
    tick();
    rst = 1'b1;
    src_en = 1'b0;
    s_valid = 1'b0;
    obs_q.delete();
    repeat (LAT + 3) tick();
    chki("t5_stale", obs_q.size(), 0);
    fill_ops(2, 13);
    begin_job(2);
    wait_done(60);
    chki("t5_results", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk8("t5_r0", obs_q[0], op1[0] - op2[0]);
      chk8("t5_r1", obs_q[1], op1[1] - op2[1]);
    end

    // Test 6: spurious pipeline valid while IDLE
    src_en = 1'b0;
    s_valid = 1'b0;
    inj = 1'b1;
    tick();
    inj = 1'b0;
    repeat (3) tick();
`ifdef ELEM_STREAM_ERR_EN
    chk1("t6_err_set", err, 1'b1);
`else
    chk1("t6_err_set", err, 1'b0);
`endif
    chk1("t6_m_valid", m_valid, 1'b0);
    fill_ops(1, 4);
    begin_job(1);
    chk1("t6_err_clr", err, 1'b0);
    wait_done(60);
    chki("t6_results", obs_q.size(), 1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elem_stream_ctrl.md
# elem_stream_ctrl

Streaming front/back-end for the fixed-latency int8 elementwise pipelines (SUB/ADD element). It accepts a ready/valid stream of int8 operand pairs, issues them to the element pipeline, and captures the pipeline's valid-only result stream into an output FIFO. The element pipeline cannot stall, so issue is gated by credits. Results are re-emitted on a ready/valid stream with an end-of-job marker.

## Interface
Parameters:
- DEPTH, 16: result FIFO entries, and maximum elements in flight (issued but not yet popped); power of two, ≥2.
- LEN_W, 16: width of the job length field.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- len  in  LEN_W  element count of the job; sampled with start.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at job completion.
- s_valid, s_ready  in/out  1  operand stream handshake.
- s_in1, s_in2  in  8  signed int8 operands.
- pe_valid  out  1  to element pipeline input_valid.
- pe_in1, pe_in2  out  8  to element pipeline in1/in2.
- pe_out_valid  in  1  from element pipeline valid.
- pe_out  in  8  from element pipeline out.
- m_valid, m_ready  out/in  1  result stream handshake.
- m_data  out  8  result.
- m_last  out  1  high with the job's final result.
- err  out  1  sticky protocol error flag (see Configuration).

## Operation
- Counters: issued, popped (LEN_W each); inflight = issued − returned; outstanding = issued − popped, 0..DEPTH.
- FSM IDLE: start=1, len>0 → latch len, clear counters and FIFO, go RUN. start=1, len=0 → done pulse next cycle, stay IDLE. Other cases: stay.
- RUN: s_ready = (issued < len) && (outstanding < DEPTH). On s_valid&&s_ready: register operands onto pe_in1/pe_in2, pe_valid=1 next cycle, issued++. When issued reaches len → DRAIN.
- DRAIN: s_ready=0. When popped reaches len → IDLE, done pulse.
- start while busy is ignored; len is not re-sampled.
- pe_out_valid=1 pushes pe_out into FIFO; results in issue order (the pipeline is in-order).
- m_valid = FIFO non-empty; pop on m_valid&&m_ready, popped++. m_last = (popped == len−1) for the head entry.
- Simultaneous issue and pop: outstanding is unchanged. Simultaneous push and pop on a full FIFO: both are allowed.
- Overflow is impossible by construction, because credits bound outstanding ≤ DEPTH.

## Timing
- Reset values: s_ready 0, pe_valid 0, pe_in1/pe_in2 0, m_valid 0, m_data 0, m_last 0, busy 0, done 0, err 0. FSM resets to IDLE, with counters and FIFO pointers at 0.
- Reset mid-job discards all state. Results that arrive later from the pipeline are pushed only if busy; they are otherwise dropped.
- start at edge t → busy=1 and s_ready eligible from t+1.
- Operand handshake at edge t → pe_valid=1 during cycle t+1 (one cycle per element, no bubbles at full rate).
- pe_out_valid at edge t → m_valid=1 during t+1 if FIFO was empty (first-word latency 1).
- Throughput: 1 element/cycle sustained when m_ready=1 and DEPTH ≥ pipeline latency + 2.
- done asserted the cycle after the final m handshake; busy falls the same cycle.

## Configuration
- ELEM_STREAM_ERR_EN defined: err is set sticky (cleared only by reset or the next accepted start) on any of these:
  - pe_out_valid with inflight==0;
  - a push into a full FIFO;
  - pe_out_valid while IDLE.
- ELEM_STREAM_ERR_EN undefined: err tied to 0 and the check logic is omitted; the offending pushes are silently dropped.

## Test plan
- len=4, s_valid always 1, m_ready=1, pipeline model latency 9 (out = in1−in2): pe_valid for 4 consecutive cycles, then m_data sequence matches; m_last on the 4th result; done one cycle after.
- DEPTH=4, len=10, m_ready=0: exactly 4 issues, then s_ready=0. Raise m_ready → remaining 6 issue; 10 results in order.
- len=0 start → done pulse next cycle, busy stays 0, no pe_valid.
- start with len=8 pulsed again mid-job with len=3 → ignored; 8 results returned; m_last on the 8th.
- Assert rst low after 3 issues, then restart len=2: outputs are 0 during reset; only 2 results emitted, and stale pipeline outputs are not emitted.
- With ELEM_STREAM_ERR_EN: pe_out_valid=1 injected in IDLE → err=1 and held; next start clears err. Without the macro: err stays 0.
